// File: rtl/rotacion_izquierda_secuencial.sv
// Iterative rotate-left unit: one bit position per clock under a start/busy/done handshake.
// Inverse of the combinational rotate-right shifter (codes 8-15 pass the operand through).
module rotacion_izquierda_secuencial #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [3:0]   b,
    output logic [N-1:0] z,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [N-1:0]  acc, acc_nx, z_nx, rot_c;
    logic [CW-1:0] cnt, cnt_nx, amt_c;
    logic          busy_nx, done_nx;

    // Codes 8-15 are a pass-through in the rotate-right shifter, so they rotate by zero here.
    assign amt_c = b[3] ? CW'(0) : b;
    assign rot_c = {acc[N-2:0], acc[N-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            z     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            z     <= z_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Next state, datapath and registered-output next values.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        z_nx     = z;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nx  = a;
                    cnt_nx  = amt_c;
                    busy_nx = 1'b1;
                    if (amt_c == CW'(0)) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        z_nx     = a;
                    end else begin
                        state_nx = ROT;
                    end
                end
            end
            ROT: begin
                acc_nx  = rot_c;
                cnt_nx  = cnt - CW'(1);
                busy_nx = 1'b1;
                if (cnt == CW'(1)) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    z_nx     = rot_c;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rotacion_izquierda_secuencial.sv
// Self-checking bench for rotacion_izquierda_secuencial against an arithmetic rotate model.
module tb_rotacion_izquierda_secuencial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] z;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    rotacion_izquierda_secuencial #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .z     (z),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff_amt(input logic [3:0] s);
        return (s < 4'd8) ? int'(s) : 0;
    endfunction

    function automatic logic [7:0] rotl_m(input logic [7:0] x, input logic [3:0] s);
        int v;
        int k;
        v = int'(x);
        k = eff_amt(s);
        return 8'(((v << k) | (v >> (8 - k))) & 255);
    endfunction

    function automatic logic [7:0] rotr_m(input logic [7:0] x, input logic [3:0] s);
        int v;
        int k;
        v = int'(x);
        k = eff_amt(s);
        return 8'(((v >> k) | (v << (8 - k))) & 255);
    endfunction

    // Pulse start for one cycle, then wait (bounded) for done; lat counts cycles after the accepting edge.
    task automatic do_op(input logic [7:0] ai, input logic [3:0] bi,
                         output logic [7:0] zr, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        a     = ai;
        b     = bi;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) bcnt++;
        zr = z;
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] zr;
        int lat, bc;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (z !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: z=%h busy=%b done=%b, required z=00 busy=0 done=0", z, busy, done);
        end
        rst_n = 1'b1;
        do_op(8'h5A, 4'd1, zr, lat, bc);
        checks++;
        if (zr !== 8'hB4 || lat != 2) begin
            errors++;
            $display("FAIL reset_first_op: z=%h lat=%0d, required z=b4 lat=2", zr, lat);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done_pulse: done=%b one cycle later, required 0", done);
        end
        // Asynchronous assertion between edges while a b=7 operation is in flight.
        start = 1'b1;
        a     = 8'h01;
        b     = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (z !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: z=%h busy=%b done=%b, required z=00 busy=0 done=0", z, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] zr;
        int lat, bc;
        do_op(8'hB4, 4'd3, zr, lat, bc);
        checks++;
        if (zr !== 8'hA5 || lat != 4 || bc != 4) begin
            errors++;
            $display("FAIL basic_op: z=%h lat=%0d busy_cycles=%0d, required z=a5 lat=4 busy_cycles=4", zr, lat, bc);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (z !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: z=%h busy=%b done=%b, required z=a5 busy=0 done=0", z, busy, done);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [4];
        logic [3:0] tb_ [4];
        logic [7:0] tz [4];
        int         tl [4];
        logic [7:0] zr;
        int lat, bc;
        ta = '{8'h81, 8'h01, 8'hC3, 8'hC3};
        tb_ = '{4'd0, 4'd7, 4'd9, 4'd15};
        tz = '{8'h81, 8'h80, 8'hC3, 8'hC3};
        tl = '{1, 8, 1, 1};
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb_[i], zr, lat, bc);
            checks++;
            if (zr !== tz[i] || lat != tl[i]) begin
                errors++;
                $display("FAIL boundary_b%0d: z=%h lat=%0d, required z=%h lat=%0d", tb_[i], zr, lat, tz[i], tl[i]);
            end
        end
    endtask

    task automatic test_inverse();
        logic [7:0] zr, src;
        int lat, bc, bad;
        bad = 0;
        for (int av = 0; av < 256; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                src = rotr_m(8'(av), 4'(bv));
                do_op(src, 4'(bv), zr, lat, bc);
                checks++;
                if (zr !== 8'(av) || zr !== rotl_m(src, 4'(bv)) || lat != eff_amt(4'(bv)) + 1) begin
                    errors++;
                    if (bad < 10)
                        $display("FAIL inverse a=%h b=%0d: z=%h lat=%0d, required z=%h lat=%0d",
                                 av[7:0], bv, zr, lat, av[7:0], eff_amt(4'(bv)) + 1);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] zr, ai;
        logic [3:0] bi;
        int lat, bc;
        for (int i = 0; i < 200; i++) begin
            ai = 8'($urandom_range(255, 0));
            bi = 4'($urandom_range(15, 0));
            do_op(ai, bi, zr, lat, bc);
            checks++;
            if (zr !== rotl_m(ai, bi) || lat != eff_amt(bi) + 1 || bc != eff_amt(bi) + 1) begin
                errors++;
                $display("FAIL random a=%h b=%0d: z=%h lat=%0d busy_cycles=%0d, required z=%h lat=%0d",
                         ai, bi, zr, lat, bc, rotl_m(ai, bi), eff_amt(bi) + 1);
            end
        end
    endtask

    task automatic test_handshake();
        logic [7:0] a1;
        int cyc;
        a1 = 8'($urandom_range(255, 0));
        @(negedge clk);
        start = 1'b1;
        a     = a1;
        b     = 4'd6;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        @(negedge clk);
        cyc++;
        start = 1'b1;
        a     = ~a1;
        b     = 4'd1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || cyc != 7 || z !== rotl_m(a1, 4'd6)) begin
            errors++;
            $display("FAIL handshake_rot: done=%b cyc=%0d z=%h, required done=1 cyc=7 z=%h", done, cyc, z, rotl_m(a1, 4'd6));
        end
        start = 1'b1;
        a     = 8'h5A;
        b     = 4'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL handshake_done_idle: busy=%b done=%b, required busy=0 done=0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || z !== rotl_m(a1, 4'd6)) begin
            errors++;
            $display("FAIL handshake_done_ignored: busy=%b done=%b z=%h, required busy=0 done=0 z=%h",
                     busy, done, z, rotl_m(a1, 4'd6));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ai;
        int prev, pulses, prev_done;
        ai        = 8'($urandom_range(255, 0));
        prev      = -1;
        pulses    = 0;
        prev_done = 0;
        @(negedge clk);
        start = 1'b1;
        a     = ai;
        b     = 4'd2;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                checks++;
                if (z !== rotl_m(ai, 4'd2) || prev_done != 0 || (prev >= 0 && c - prev != 4)) begin
                    errors++;
                    $display("FAIL back_to_back c=%0d: z=%h spacing=%0d, required z=%h spacing=4",
                             c, z, c - prev, rotl_m(ai, 4'd2));
                end
                prev = c;
            end
            prev_done = (done === 1'b1) ? 1 : 0;
        end
        start = 1'b0;
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL back_to_back_count: pulses=%0d, required 10", pulses);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic [7:0] zr, ai;
        int lat, bc, seen;
        ai = 8'h3C;
        @(negedge clk);
        start = 1'b1;
        a     = ai;
        b     = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || z !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b z=%h done=%b, required busy=0 z=00 done=0", busy, z, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: active cycles=%0d after reset, required 0", seen);
        end
        do_op(8'hE1, 4'd5, zr, lat, bc);
        checks++;
        if (zr !== rotl_m(8'hE1, 4'd5) || lat != 6) begin
            errors++;
            $display("FAIL reset_mid_recover: z=%h lat=%0d, required z=%h lat=6", zr, lat, rotl_m(8'hE1, 4'd5));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_inverse();
        test_random();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
